// File: rtl/approx_prod_divider_if.sv
// Handshake bundle for approx_prod_divider: operand side and result side.
// master drives operands and consumes results; slave is the divider.
interface approx_prod_divider_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/approx_prod_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// APPROX_PROD_DIVIDER_EARLY_EXIT_EN skips the dividend's leading zeros.
module approx_prod_divider #(
    parameter int DW = 16,
    parameter int VW = 8,
    parameter int CW = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    approx_prod_divider_if.slave     bus,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [VW:0]   prem;
    logic [DW-1:0] qsr;
    logic [VW-1:0] dvs;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          div_zero_q;

    logic [VW:0]   shifted;
    logic [VW+1:0] trial;
    logic          qbit;
    logic [VW:0]   prem_nxt;
    logic [CW-1:0] start_cnt;
    logic [DW-1:0] start_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;

    // Extra top bit of trial is the borrow: set means restore.
    always_comb begin
        shifted  = {prem[VW-1:0], qsr[DW-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs};
        qbit     = ~trial[VW+1];
        prem_nxt = qbit ? trial[VW:0] : shifted;
    end

`ifdef APPROX_PROD_DIVIDER_EARLY_EXIT_EN
    function automatic logic [CW-1:0] msb_idx(
        input logic [DW-1:0] v
    );
        msb_idx = '0;
        for (int i = 0; i < DW; i++)
            if (v[i]) msb_idx = CW'(i);
    endfunction

    // Align the top set bit to the MSB so the zeros shifted in
    // below it drop out exactly as the last quotient bit lands.
    always_comb begin
        start_cnt = msb_idx(bus.dividend);
        start_q   = bus.dividend << (CW'(DW - 1) - start_cnt);
    end
`else
    always_comb begin
        start_cnt = CW'(DW - 1);
        start_q   = bus.dividend;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prem        <= '0;
            qsr         <= '0;
            dvs         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvs        <= bus.divisor;
                        in_ready_q <= 1'b0;
                        busy       <= 1'b1;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[VW-1:0];
                            div_zero_q  <= 1'b1;
                        end
`ifdef APPROX_PROD_DIVIDER_EARLY_EXIT_EN
                        else if (bus.dividend == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= '0;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b0;
                        end
`endif
                        else begin
                            state <= CALC;
                            cnt   <= start_cnt;
                            prem  <= '0;
                            qsr   <= start_q;
                        end
                    end
                end
                CALC: begin
                    prem <= prem_nxt;
                    qsr  <= {qsr[DW-2:0], qbit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        quotient_q  <= {qsr[DW-2:0], qbit};
                        remainder_q <= prem_nxt[VW-1:0];
                        div_zero_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_prod_divider.sv
// Directed-vector bench for approx_prod_divider.
// Latency is counted in cycles from the cycle in_valid is presented.
module tb_approx_prod_divider;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    approx_prod_divider_if #(.DW(16), .VW(8)) bus ();

    approx_prod_divider #(.DW(16), .VW(8), .CW(5)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

`ifdef APPROX_PROD_DIVIDER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a,
                          input logic [7:0]  b,
                          output int         lat);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        step();
        lat = 1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string       tag,
                          input logic [15:0] a,
                          input logic [7:0]  b,
                          input logic [15:0] q,
                          input logic [7:0]  r,
                          input logic        dz,
                          input int          lat_def,
                          input int          lat_ee);
        int lat;
        bus.out_ready = 1'b1;
        launch(a, b, lat);
        check({tag, "_lat"}, lat, EE ? lat_ee : lat_def);
        check({tag, "_vld"}, bus.out_valid, 1'b1);
        check({tag, "_q"}, bus.quotient, q);
        check({tag, "_r"}, bus.remainder, r);
        check({tag, "_dz"}, bus.div_zero, dz);
        check({tag, "_busy"}, busy, 1'b1);
        step();
        check({tag, "_vld0"}, bus.out_valid, 1'b0);
        check({tag, "_rdy1"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int rises;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("rst_rdy", bus.in_ready, 1'b1);
        check("rst_vld", bus.out_valid, 1'b0);
        check("rst_q", bus.quotient, 16'h0);
        check("rst_r", bus.remainder, 8'h0);
        check("rst_dz", bus.div_zero, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        step();

        run_op("basic", 16'h3F01, 8'd127, 16'd127, 8'd0, 1'b0, 17, 15);

        bus.out_ready = 1'b0;
        launch(16'd1000, 8'd7, lat);
        check("bp_lat", lat, EE ? 11 : 17);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 3 == 0);
            bus.dividend = 16'h1111;
            bus.divisor  = 8'd3;
            check("bp_vld", bus.out_valid, 1'b1);
            check("bp_q", bus.quotient, 16'd142);
            check("bp_r", bus.remainder, 8'd6);
            check("bp_rdy0", bus.in_ready, 1'b0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_vld_last", bus.out_valid, 1'b1);
        check("bp_q_last", bus.quotient, 16'd142);
        step();
        check("bp_vld0", bus.out_valid, 1'b0);
        check("bp_rdy1", bus.in_ready, 1'b1);
        check("bp_q_hold", bus.quotient, 16'd142);
        check("bp_r_hold", bus.remainder, 8'd6);

        run_op("dz", 16'hABCD, 8'd0, 16'hFFFF, 8'hCD, 1'b1, 1, 1);

        bus.out_ready = 1'b1;
        bus.dividend  = 16'hFFFF;
        bus.divisor   = 8'd255;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rdy", bus.in_ready, 1'b1);
        check("mid_busy0", busy, 1'b0);
        check("mid_q0", bus.quotient, 16'h0);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) rises++;
            step();
        end
        check("mid_novld", rises, 0);
        run_op("ffff", 16'hFFFF, 8'd255, 16'd257, 8'd0, 1'b0, 17, 17);

        run_op("ee5", 16'h0005, 8'd2, 16'd2, 8'd1, 1'b0, 17, 4);
        run_op("zero", 16'h0000, 8'd5, 16'd0, 8'd0, 1'b0, 17, 1);
        run_op("div1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 17, 17);
        run_op("r45", 16'd300, 8'd255, 16'd1, 8'd45, 1'b0, 17, 10);
        run_op("hex", 16'h1234, 8'h10, 16'h0123, 8'h4, 1'b0, 17, 14);
        run_op("small", 16'd200, 8'd201, 16'd0, 8'd200, 1'b0, 17, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
